// File: rtl/regfile_wb_arb_pkg.sv
// Shared widths, requester ids and the buffered writeback entry type for the
// ALU/LSU regfile writeback arbiter.
`ifndef REG_BUS
`define REG_BUS 4:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 63:0
`endif
`ifndef ZERO_64
`define ZERO_64 64'h0
`endif
`ifndef REQ_ALU
`define REQ_ALU 1'b0
`endif
`ifndef REQ_LSU
`define REQ_LSU 1'b1
`endif

package regfile_wb_arb_pkg;
  typedef logic [`REG_BUS]  reg_t;
  typedef logic [`DATA_BUS] data_t;

  localparam int   NUM_REQ = 2;
  localparam logic REQ_ALU = `REQ_ALU;
  localparam logic REQ_LSU = `REQ_LSU;

  typedef struct packed {
    reg_t  addr;
    data_t data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);
endpackage

// File: rtl/regfile_wb_arb_if.sv
// Requester handshakes plus the regfile write port of the writeback arbiter.
interface regfile_wb_arb_if;
  import regfile_wb_arb_pkg::*;

  logic  alu_valid, alu_ready;
  reg_t  alu_addr;
  data_t alu_data;
  logic  lsu_valid, lsu_ready;
  reg_t  lsu_addr;
  data_t lsu_data;
  logic  flush;
  logic  Rw_en;
  reg_t  Rw_addr;
  data_t Rw;
  logic  idle;

  modport master (
    output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data, flush,
    input  alu_ready, lsu_ready, Rw_en, Rw_addr, Rw, idle
  );
  modport slave (
    input  alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data, flush,
    output alu_ready, lsu_ready, Rw_en, Rw_addr, Rw, idle
  );
endinterface

// File: rtl/regfile_wb_arb_wb_fifo.sv
// Two-entry writeback buffer: 1-bit wrapping pointers, 2-bit count, sync flush.
module wb_fifo #(
  parameter int FIFO_DEPTH = 2,
  parameter int W          = 69
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         flush,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);
  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign dout    = mem_q[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = din;
        wptr_d        = ~wptr_q;
      end
      if (do_pop) rptr_d = ~rptr_q;
      count_d = count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q   <= '{default: '0};
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/regfile_wb_arb.sv
// Buffers ALU and LSU writebacks and merges them onto the single regfile write
// port with round-robin arbitration; writes to x0 are consumed silently.
module regfile_wb_arb
  import regfile_wb_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_arb_if.slave  bus
);
  logic      [NUM_REQ-1:0]      push, pop, empty, full;
  logic      [NUM_REQ-1:0][1:0] count;
  wb_entry_t [NUM_REQ-1:0]      din, dout;

  logic  last_grant_q, last_grant_d;
  logic  rw_en_q, rw_en_d;
  reg_t  rw_addr_q, rw_addr_d;
  data_t rw_q, rw_d;
  logic  grant, pop_any;

  assign din[REQ_ALU]  = '{addr: bus.alu_addr, data: bus.alu_data};
  assign din[REQ_LSU]  = '{addr: bus.lsu_addr, data: bus.lsu_data};
  assign push[REQ_ALU] = bus.alu_valid & ~full[REQ_ALU];
  assign push[REQ_LSU] = bus.lsu_valid & ~full[REQ_LSU];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[i]),
      .din   (din[i]),
      .pop   (pop[i]),
      .flush (bus.flush),
      .dout  (dout[i]),
      .count (count[i]),
      .empty (empty[i]),
      .full  (full[i])
    );
  end

  // On contention the requester that did not win last time is served.
  always_comb begin
    grant        = REQ_ALU;
    pop_any      = 1'b0;
    pop          = '0;
    last_grant_d = last_grant_q;
    rw_en_d      = 1'b0;
    rw_addr_d    = rw_addr_q;
    rw_d         = rw_q;
    if (!bus.flush) begin
      if (!empty[REQ_ALU] && !empty[REQ_LSU]) begin
        pop_any = 1'b1;
        grant   = ~last_grant_q;
      end else if (!empty[REQ_ALU]) begin
        pop_any = 1'b1;
        grant   = REQ_ALU;
      end else if (!empty[REQ_LSU]) begin
        pop_any = 1'b1;
        grant   = REQ_LSU;
      end
      if (pop_any) begin
        pop[grant]   = 1'b1;
        last_grant_d = grant;
        if (dout[grant].addr != '0) begin
          rw_en_d   = 1'b1;
          rw_addr_d = dout[grant].addr;
          rw_d      = dout[grant].data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= REQ_LSU;
      rw_en_q      <= 1'b0;
      rw_addr_q    <= '0;
      rw_q         <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rw_en_q      <= rw_en_d;
      rw_addr_q    <= rw_addr_d;
      rw_q         <= rw_d;
    end
  end

  assign bus.alu_ready = ~full[REQ_ALU];
  assign bus.lsu_ready = ~full[REQ_LSU];
  assign bus.Rw_en     = rw_en_q;
  assign bus.Rw_addr   = rw_addr_q;
  assign bus.Rw        = rw_q;
  assign bus.idle      = (count[REQ_ALU] == 2'd0) && (count[REQ_LSU] == 2'd0) && !rw_en_q;
endmodule

// File: tb/tb_regfile_wb_arb.sv
// Directed stimulus with a cycle-stamped scoreboard of expected regfile writes.
module tb_regfile_wb_arb;
  import regfile_wb_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_arb_if bus ();
  regfile_wb_arb #(.FIFO_DEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    reg_t  addr;
    data_t data;
    int    cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected write lands 'dly' negedges after the negedge the request is driven.
  task automatic expect_wr(reg_t a, data_t d, int dly);
    exp_t e;
    int   k;
    e.addr = a; e.data = d; e.cyc = cyc + dly;
    k = 0;
    while (k < sb.size() && sb[k].cyc <= e.cyc) k++;
    sb.insert(k, e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      checks++; errors++;
      $display("FAIL missing_write: got none expected addr %0h data %0h at cycle %0d", mon_e.addr, mon_e.data, mon_e.cyc);
    end
    if (bus.Rw_en === 1'b1) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none (cycle %0d)", bus.Rw_addr, bus.Rw, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 64'(bus.Rw_addr), 64'(mon_e.addr));
        chk("wr_data", bus.Rw, mon_e.data);
        chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic drive(logic av, reg_t aa, data_t ad, logic lv, reg_t la, data_t ld);
    @(negedge clk);
    bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
    bus.lsu_valid = lv; bus.lsu_addr = la; bus.lsu_data = ld;
    bus.flush     = 1'b0;
  endtask

  task automatic quiet(int n);
    repeat (n) drive(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_rw_en"},   64'(bus.Rw_en),     64'd0);
    chk({tag, "_rw_addr"}, 64'(bus.Rw_addr),   64'd0);
    chk({tag, "_rw"},      bus.Rw,             64'd0);
    chk({tag, "_alu_rdy"}, 64'(bus.alu_ready), 64'd1);
    chk({tag, "_lsu_rdy"}, 64'(bus.lsu_ready), 64'd1);
    chk({tag, "_idle"},    64'(bus.idle),      64'd1);
  endtask

  initial begin
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.lsu_valid = 1'b0; bus.lsu_addr = '0; bus.lsu_data = '0;
    bus.flush = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b1;

    // Simultaneous ALU/LSU: ALU wins first contention.
    drive(1'b1, 5'd3, 64'h1, 1'b1, 5'd4, 64'h2);
    expect_wr(5'd3, 64'h1, 2);
    expect_wr(5'd4, 64'h2, 3);
    quiet(4);
    // Next contention: LSU was served last, so ALU wins again.
    drive(1'b1, 5'd10, 64'h11, 1'b1, 5'd12, 64'h13);
    expect_wr(5'd10, 64'h11, 2);
    expect_wr(5'd12, 64'h13, 3);
    quiet(4);

    // Single ALU write, two-cycle latency, idle afterwards.
    drive(1'b1, 5'd5, 64'hA5, 1'b0, '0, '0);
    expect_wr(5'd5, 64'hA5, 2);
    quiet(1);
    chk("idle_busy", 64'(bus.idle), 64'd0);
    quiet(2);
    chk("idle_after", 64'(bus.idle), 64'd1);
    quiet(1);

    // ALU backs up behind an LSU grant; ready drops at count 2, order kept.
    drive(1'b1, 5'd1, 64'h1, 1'b1, 5'd20, 64'h14);
    expect_wr(5'd20, 64'h14, 2);
    expect_wr(5'd1, 64'h1, 3);
    drive(1'b1, 5'd2, 64'h2, 1'b0, '0, '0);
    expect_wr(5'd2, 64'h2, 3);
    drive(1'b1, 5'd3, 64'h3, 1'b0, '0, '0);
    chk("alu_ready_full", 64'(bus.alu_ready), 64'd0);
    drive(1'b1, 5'd3, 64'h3, 1'b0, '0, '0);
    chk("alu_ready_back", 64'(bus.alu_ready), 64'd1);
    expect_wr(5'd3, 64'h3, 2);
    quiet(4);

    // LSU write to x0 is swallowed; following addr 7 write follows a cycle later.
    drive(1'b0, '0, '0, 1'b1, 5'd0, 64'hDEAD);
    drive(1'b0, '0, '0, 1'b1, 5'd7, 64'h77);
    expect_wr(5'd7, 64'h77, 2);
    quiet(1);
    chk("x0_no_en", 64'(bus.Rw_en), 64'd0);
    chk("x0_addr_hold", 64'(bus.Rw_addr), 64'd3);
    chk("x0_data_hold", bus.Rw, 64'h3);
    quiet(3);

    // Fill buffers, then flush with new pushes offered on the flush edge.
    drive(1'b1, 5'h11, 64'hA1, 1'b1, 5'h12, 64'hB1);
    expect_wr(5'h11, 64'hA1, 2);
    expect_wr(5'h12, 64'hB1, 3);
    drive(1'b1, 5'h13, 64'hA2, 1'b1, 5'h14, 64'hB2);
    drive(1'b1, 5'h15, 64'hA3, 1'b0, '0, '0);
    chk("lsu_ready_full", 64'(bus.lsu_ready), 64'd0);
    drive(1'b1, 5'h1E, 64'hEE, 1'b1, 5'h1F, 64'hFF);
    bus.flush = 1'b1;
    chk("alu_ready_full2", 64'(bus.alu_ready), 64'd0);
    quiet(1);
    chk("flush_rw_en", 64'(bus.Rw_en), 64'd0);
    chk("flush_alu_rdy", 64'(bus.alu_ready), 64'd1);
    chk("flush_lsu_rdy", 64'(bus.lsu_ready), 64'd1);
    chk("flush_idle", 64'(bus.idle), 64'd1);
    // last_grant survives the flush: LSU served last, ALU wins.
    drive(1'b1, 5'h16, 64'hC1, 1'b1, 5'h17, 64'hC2);
    expect_wr(5'h16, 64'hC1, 2);
    expect_wr(5'h17, 64'hC2, 3);
    quiet(4);

    // Asynchronous reset with two entries buffered.
    drive(1'b1, 5'h18, 64'hD1, 1'b1, 5'h19, 64'hD2);
    quiet(1);
    #2 rst = 1'b0;
    #1 chk_reset_outs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    quiet(5);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arb.md
REGFILE_WB_ARB -- requirements
Module: regfile_wb_arb

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, number of entries per requester buffer; only the value 2 is supported.
REQ-002 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: alu_valid  input  1  ALU writeback request valid.
REQ-005 Port: alu_ready  output  1  ALU request accepted when alu_valid && alu_ready.
REQ-006 Port: alu_addr  input  `REG_BUS (5)  ALU destination register.
REQ-007 Port: alu_data  input  `DATA_BUS (64)  ALU writeback data.
REQ-008 Port: lsu_valid / lsu_ready / lsu_addr / lsu_data  in/out/in/in  1/1/5/64  LSU requester; same semantics as the ALU ports.
REQ-009 Port: flush  input  1  synchronous discard of all buffered writebacks.
REQ-010 Port: Rw_en  output  1  regfile write enable.
REQ-011 Port: Rw_addr  output  5  regfile write address.
REQ-012 Port: Rw  output  64  regfile write data.
REQ-013 Port: idle  output  1  high when both buffers are empty and Rw_en is 0.

Function
REQ-014 Each requester owns one FIFO_DEPTH-entry FIFO of {addr, data}; ready = (count < 2), derived combinationally from registered count only.
REQ-015 No pass-through: a request accepted at edge N is first visible at a FIFO head in cycle N+1.
REQ-016 Grant cycle: if exactly one head is valid, that FIFO is popped; if both are valid, the FIFO not granted last (last_grant register) is popped.
REQ-017 last_grant updates to the popped requester on every pop; its reset value is LSU, so ALU wins the first contention.
REQ-018 The popped entry loads Rw_addr/Rw at the end of the grant cycle; Rw_en = 1 in the next cycle unless addr == 0, so accept-to-write latency is 2 cycles.
REQ-019 Entries with addr 0 are popped and count as a grant (last_grant updates) but produce Rw_en = 0, with Rw_addr/Rw left unchanged.
REQ-020 Rw_en is a one-cycle pulse per popped entry; back-to-back pops give Rw_en high on consecutive cycles.
REQ-021 Push and pop in the same cycle at count 1 leave count at 1, and FIFO order is preserved.
REQ-022 Push is impossible at count 2 because ready is low; pop at count 2 raises ready in the following cycle.
REQ-023 Within one requester, writes reach the port in acceptance order; no ordering is guaranteed between requesters.
REQ-024 On flush = 1 at an edge: both FIFO counts go to 0, Rw_en goes to 0 next cycle, that cycle's pushes and pop are discarded, and last_grant is unchanged.
REQ-025 Pointer arithmetic: 1-bit read and write pointers, 2-bit count; pointers wrap modulo 2.

Reset
REQ-026 While rst = 0: counts = 0, pointers = 0, last_grant = LSU, Rw_en = 0, Rw_addr = 0, Rw = 0, alu_ready = lsu_ready = 1, idle = 1.
REQ-027 Reset asserted mid-operation discards all buffered entries immediately; no write is issued on the first edge after deassertion.

Structure
REQ-028 Widths come from the shared defines.v (`REG_BUS, `DATA_BUS, `ZERO_64); add REQ_ALU = 1'b0 and REQ_LSU = 1'b1 there.
REQ-029 The FIFO is one sub-module, wb_fifo (FIFO_DEPTH = 2, 69-bit entries, push/pop/flush, count/empty/full), instantiated twice.
REQ-030 Arbitration and output registers live in regfile_wb_arb; the regfile itself is not instantiated inside it.

Verification
REQ-031 Single ALU write (addr 5, data 64'hA5) accepted at edge 0 -> Rw_en = 1, Rw_addr = 5, Rw = 64'hA5 in cycle 2 only; idle = 1 from cycle 3.
REQ-032 ALU (3, 1) and LSU (4, 2) accepted at the same edge -> ALU writes in cycle 2 and LSU in cycle 3; the next contention is won by ALU.
REQ-033 Three ALU pushes back-to-back with grants flowing -> at most 2 buffered, alu_ready drops when count = 2, and writes 1, 2, 3 appear in order.
REQ-034 LSU write to addr 0 followed by addr 7 -> no Rw_en for addr 0; Rw_en for addr 7 one cycle later.
REQ-035 Both FIFOs full, then flush pulsed -> no Rw_en in the following cycle, both readies = 1, idle = 1.
REQ-036 rst driven low between clock edges with 2 entries buffered -> outputs reach reset values immediately; no writes after release.
